// File: rtl/bit_collector_32_pkg.sv
// Shared defaults and state encoding for the bit collector and its decoder.
package bit_collector_32_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int IDX_W_DEF = 5;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

endpackage

// File: rtl/bit_collector_32_if.sv
// Bit-serial input plus word-parallel output handshake of the collector.
interface bit_collector_32_if
  import bit_collector_32_pkg::*;
;
  logic                 flush;
  logic                 in_bit;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH_DEF-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [IDX_W_DEF-1:0] bit_count;

  modport master (
    output flush, in_bit, in_valid, out_ready,
    input  in_ready, out_data, out_valid, bit_count
  );

  modport slave (
    input  flush, in_bit, in_valid, out_ready,
    output in_ready, out_data, out_valid, bit_count
  );
endinterface

// File: rtl/bit_collector_32_decoder.sv
// Index to one-hot enable decode, gated by a single enable; reusable for
// register-file write enables.
module decoder_5_32
  import bit_collector_32_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [WIDTH-1:0] onehot
);

  // NOTE: assigning every always_comb output before any branch prevents latches.
  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/bit_collector_32.sv
// Serial-to-parallel collector: accepted bit n of a word lands in word bit n,
// with a valid/ready handshake on both the bit and the word side.
module bit_collector_32
  import bit_collector_32_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input logic               clock,
  input logic               reset,
  bit_collector_32_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] count;
  logic [IDX_W-1:0] count_next;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] write_en;
  logic             accept;
  logic             handoff;

  // In FULL the input is ready exactly when the word leaves, so a new word
  // starts on the handoff edge without a bubble.
  assign bus.in_ready = ~bus.flush & ((state == FILL) | bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;
  assign handoff      = (state == FULL) & bus.out_ready & ~bus.flush;

  always_comb begin
    state_next = state;
    count_next = count;
    if (bus.flush) begin
      state_next = FILL;
      count_next = '0;
    end else begin
      unique case (state)
        FILL: begin
          if (accept) begin
            if (count == LAST_IDX) begin
              state_next = FULL;
              count_next = '0;
            end else begin
              count_next = count + 1'b1;
            end
          end
        end
        FULL: begin
          if (handoff) begin
            state_next = FILL;
            count_next = accept ? IDX_W'(1) : '0;
          end
        end
        default: state_next = FILL;
      endcase
    end
  end

  // The counter has already wrapped to 0 in FULL, so a bit accepted on the
  // handoff edge decodes straight into bit 0 of the next word.
  decoder_5_32 #(
    .IDX_W (IDX_W),
    .WIDTH (WIDTH)
  ) u_decoder (
    .idx    (count),
    .en     (accept),
    .onehot (write_en)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= FILL;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Bit flops clear on handoff or flush, which keeps a partial word
  // zero-extended; the write enable wins so a handoff-cycle bit is kept.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (write_en[i])               data[i] <= bus.in_bit;
        else if (handoff || bus.flush) data[i] <= 1'b0;
      end
    end
  end

  assign bus.out_data  = data;
  assign bus.out_valid = (state == FULL);
  assign bus.bit_count = count;

endmodule

// File: tb/tb_bit_collector_32.sv
// Self-checking bench: directed scenarios plus random sparse traffic against a
// bit-list model of the collector and a word scoreboard.
module tb_bit_collector_32;

  logic clock = 1'b0;
  logic reset = 1'b1;

  bit_collector_32_if bus ();

  bit_collector_32 dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the word is the list of accepted bits; full once 32 have arrived.
  logic [31:0] m_word;
  int          m_n;
  bit          m_full;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_word = '0;
      m_n    = 0;
      m_full = 1'b0;
    end else if (bus.flush) begin
      m_word = '0;
      m_n    = 0;
      m_full = 1'b0;
    end else if (m_full) begin
      if (bus.out_ready) begin
        m_full = 1'b0;
        m_n    = bus.in_valid ? 1 : 0;
        m_word = (bus.in_valid && bus.in_bit) ? 32'd1 : 32'd0;
      end
    end else if (bus.in_valid) begin
      m_word[m_n] = bus.in_bit;
      m_n++;
      if (m_n == 32) begin
        m_full = 1'b1;
        m_n    = 0;
      end
    end
  end

  bit          chk_en = 1'b0;
  bit          sb_en  = 1'b0;
  bit          rand_or = 1'b0;
  logic [31:0] sb[$];

  always @(negedge clock) begin
    if (chk_en && !reset) begin
      check("out_valid", 32'(bus.out_valid), 32'(m_full));
      check("out_data",  bus.out_data, m_word);
      check("bit_count", 32'(bus.bit_count), 32'(m_n));
      check("in_ready",  32'(bus.in_ready), 32'(!bus.flush && (!m_full || bus.out_ready)));
      if (sb_en && bus.out_valid && bus.out_ready && !bus.flush) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL sb_underflow: got word %h, expected none", bus.out_data);
        end else begin
          check("sb_word", bus.out_data, sb.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b, output int tries);
    bit done = 1'b0;
    tries = 0;
    bus.in_valid = 1'b1;
    bus.in_bit   = b;
    for (int t = 0; t < 200 && !done; t++) begin
      if (rand_or) bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clock);
      done = bus.in_ready;
      tries++;
      step();
    end
    bus.in_valid = 1'b0;
    if (!done) check("accept_timeout", 32'(done), 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, output int stalls);
    int tries;
    stalls = 0;
    for (int i = 0; i < 32; i++) begin
      send_bit(w[i], tries);
      stalls += tries - 1;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          tries;
    int          stalls;
    logic [31:0] w;

    bus.flush     = 1'b0;
    bus.in_bit    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #23 reset = 1'b0;
    step();
    chk_en = 1'b1;
    @(negedge clock);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  bus.out_data, 32'd0);
    check("rst_bit_count", 32'(bus.bit_count), 32'd0);
    check("rst_in_ready",  32'(bus.in_ready), 32'd1);
    step();

    // Fill under backpressure.
    send_word(32'hA5C3_0F81, stalls);
    @(negedge clock);
    check("fill_out_valid", 32'(bus.out_valid), 32'd1);
    check("fill_out_data",  bus.out_data, 32'hA5C3_0F81);
    check("fill_bit_count", 32'(bus.bit_count), 32'd0);
    check("fill_in_ready",  32'(bus.in_ready), 32'd0);
    step();

    for (int k = 0; k < 10; k++) begin
      bus.in_valid = 1'b1;
      bus.in_bit   = k[0];
      @(negedge clock);
      check("bp_out_data", bus.out_data, 32'hA5C3_0F81);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      step();
    end
    bus.in_bit    = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clock);
    check("release_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clock);
    check("release_bit_count", 32'(bus.bit_count), 32'd1);
    check("release_out_data",  bus.out_data, 32'd1);
    check("release_out_valid", 32'(bus.out_valid), 32'd0);
    step();

    // Flush after 13 bits, concurrent with an offered bit.
    for (int i = 0; i < 12; i++) send_bit(1'b1, tries);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_bit   = 1'b1;
    @(negedge clock);
    check("flush_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clock);
    check("flush13_bit_count", 32'(bus.bit_count), 32'd0);
    check("flush13_out_data",  bus.out_data, 32'd0);
    check("flush13_out_valid", 32'(bus.out_valid), 32'd0);
    step();

    // Flush while FULL.
    send_word($urandom, stalls);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    @(negedge clock);
    check("flushfull_out_valid", 32'(bus.out_valid), 32'd0);
    check("flushfull_out_data",  bus.out_data, 32'd0);
    step();

    // Back-to-back words with the consumer always ready.
    bus.out_ready = 1'b1;
    send_word(32'hFFFF_FFFF, stalls);
    @(negedge clock);
    check("b2b_w1_valid", 32'(bus.out_valid), 32'd1);
    check("b2b_w1_data",  bus.out_data, 32'hFFFF_FFFF);
    step();
    w = 32'h0000_0001;
    for (int i = 0; i < 32; i++) begin
      send_bit(w[i], tries);
      stalls += tries - 1;
      if (i == 0) begin
        check("b2b_w2_first_valid", 32'(bus.out_valid), 32'd0);
        check("b2b_w2_first_data",  bus.out_data, 32'd1);
      end
    end
    check("b2b_w2_data",  bus.out_data, 32'h0000_0001);
    check("b2b_w2_valid", 32'(bus.out_valid), 32'd1);
    check("b2b_stalls",   32'(stalls), 32'd0);
    step();
    check("b2b_w2_one_cycle", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset mid-word.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 20; i++) send_bit(1'($urandom_range(0, 1)), tries);
    #3 reset = 1'b1;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_out_data",  bus.out_data, 32'd0);
    check("arst_bit_count", 32'(bus.bit_count), 32'd0);
    #2 reset = 1'b0;
    step();
    send_word(32'hFFFF_FFFF, stalls);
    check("arst_refill", bus.out_data, 32'hFFFF_FFFF);
    bus.out_ready = 1'b1;
    step();
    step();

    // Sparse random traffic with random consumer readiness.
    sb_en   = 1'b1;
    rand_or = 1'b1;
    for (int n = 0; n < 100; n++) begin
      w = $urandom;
      sb.push_back(w);
      for (int i = 0; i < 32; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          repeat ($urandom_range(1, 2)) step();
        end
        send_bit(w[i], tries);
      end
    end
    rand_or       = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) step();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
